// File: rtl/latch_feed_ctrl_pkg.sv
// Shared definitions for the latch feeder: state encodings, parameter defaults
// and the elaboration-time range check used on the phase lengths.
package latch_feed_ctrl_pkg;

    localparam int unsigned DSIZE_DEF     = 8;
    localparam int unsigned SETUP_CYC_DEF = 1;
    localparam int unsigned OPEN_CYC_DEF  = 2;
    localparam int unsigned HOLD_CYC_DEF  = 1;
    localparam int unsigned CW_DEF        = 4;
    localparam int unsigned CNT_W_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OPEN  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // True when a phase length n can be expressed by a w-bit down-counter.
    function automatic bit cyc_fits(input int unsigned n, input int unsigned w);
        return n <= ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/latch_feed_ctrl_cycle_timer.sv
// Phase timer for the latch feeder: loadable down-counter that stops at zero.
module latch_feed_ctrl_cycle_timer #(
    parameter int unsigned CW = 4
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero_c
);

    logic [CW-1:0] cnt;

    // Counts down to zero and parks there; no wrap inside a phase.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/latch_feed_ctrl.sv
// Stream-to-latch feeder: sequences SETUP/OPEN/HOLD windows around each accepted word.
// Optional LATCH_FEED_STATS_EN adds the xfer_cnt completed-transfer counter port.
module latch_feed_ctrl
    import latch_feed_ctrl_pkg::*;
#(
    parameter int unsigned DSIZE     = DSIZE_DEF,
    parameter int unsigned SETUP_CYC = SETUP_CYC_DEF,
    parameter int unsigned OPEN_CYC  = OPEN_CYC_DEF,
    parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic             in_ready,
    output logic             latch_en,
    output logic [DSIZE-1:0] latch_din,
    output logic             busy,
    output logic             done
`ifdef LATCH_FEED_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    if (OPEN_CYC == 0) begin : g_bad_open
        $error("latch_feed_ctrl: OPEN_CYC must be >= 1");
    end
    if (!cyc_fits(SETUP_CYC, CW) || !cyc_fits(OPEN_CYC, CW) || !cyc_fits(HOLD_CYC, CW)) begin : g_bad_cyc
        $error("latch_feed_ctrl: SETUP/OPEN/HOLD_CYC exceed 2**CW-1");
    end
    if (CNT_W == 0) begin : g_bad_cnt
        $error("latch_feed_ctrl: CNT_W must be >= 1");
    end

    localparam logic [CW-1:0] SETUP_LOAD = CW'((SETUP_CYC > 0) ? SETUP_CYC - 32'd1 : 32'd0);
    localparam logic [CW-1:0] OPEN_LOAD  = CW'((OPEN_CYC > 0) ? OPEN_CYC - 32'd1 : 32'd0);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLD_CYC > 0) ? HOLD_CYC - 32'd1 : 32'd0);

    state_e        state;
    state_e        state_nxt;
    logic          accept_c;
    logic          load_c;
    logic [CW-1:0] load_val_c;
    logic          zero_c;
    logic          done_nxt_c;

    latch_feed_ctrl_cycle_timer #(
        .CW(CW)
    ) u_timer (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (load_c),
        .load_val (load_val_c),
        .zero_c   (zero_c)
    );

    // Next state, timer reload on every phase entry, and the completion pulse.
    always_comb begin
        state_nxt  = state;
        load_c     = 1'b0;
        load_val_c = '0;
        done_nxt_c = 1'b0;
        accept_c   = in_valid && in_ready;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    load_c = 1'b1;
                    if (SETUP_CYC != 0) begin
                        state_nxt  = ST_SETUP;
                        load_val_c = SETUP_LOAD;
                    end else begin
                        state_nxt  = ST_OPEN;
                        load_val_c = OPEN_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                if (zero_c) begin
                    state_nxt  = ST_OPEN;
                    load_c     = 1'b1;
                    load_val_c = OPEN_LOAD;
                end
            end
            ST_OPEN: begin
                if (zero_c) begin
                    if (HOLD_CYC != 0) begin
                        state_nxt  = ST_HOLD;
                        load_c     = 1'b1;
                        load_val_c = HOLD_LOAD;
                    end else begin
                        state_nxt  = ST_IDLE;
                        done_nxt_c = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (zero_c) begin
                    state_nxt  = ST_IDLE;
                    done_nxt_c = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            latch_en  <= 1'b0;
            latch_din <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == ST_IDLE);
            latch_en <= (state_nxt == ST_OPEN);
            busy     <= (state_nxt != ST_IDLE);
            done     <= done_nxt_c;
            if (accept_c) begin
                latch_din <= in_data;
            end
        end
    end

`ifdef LATCH_FEED_STATS_EN
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (done_nxt_c) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_latch_feed_ctrl.sv
// Directed self-checking bench for latch_feed_ctrl: default timing instance plus an S=0/H=0 instance.
module tb_latch_feed_ctrl;
    import latch_feed_ctrl_pkg::*;

    logic       clock;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       latch_en;
    logic [7:0] latch_din;
    logic       busy;
    logic       done;

    logic       f_valid;
    logic [7:0] f_data;
    logic       f_in_ready;
    logic       f_latch_en;
    logic [7:0] f_latch_din;
    logic       f_busy;
    logic       f_done;

`ifdef LATCH_FEED_STATS_EN
    logic [15:0] xfer_cnt;
    logic [1:0]  f_xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;

    latch_feed_ctrl u_dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .latch_en  (latch_en),
        .latch_din (latch_din),
        .busy      (busy),
        .done      (done)
`ifdef LATCH_FEED_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    latch_feed_ctrl #(
        .DSIZE(8), .SETUP_CYC(0), .OPEN_CYC(2), .HOLD_CYC(0), .CW(4), .CNT_W(2)
    ) u_fast (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (f_valid),
        .in_data   (f_data),
        .in_ready  (f_in_ready),
        .latch_en  (f_latch_en),
        .latch_din (f_latch_din),
        .busy      (f_busy),
        .done      (f_done)
`ifdef LATCH_FEED_STATS_EN
        ,
        .xfer_cnt  (f_xfer_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready timeout in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; f_valid = 1'b0; f_data = '0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b req 0", in_ready); end
        checks++; if (latch_en !== 1'b0) begin errors++; $display("FAIL reset_latch_en got %b req 0", latch_en); end
        checks++; if (latch_din !== 8'h00) begin errors++; $display("FAIL reset_latch_din got %h req 00", latch_din); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b req 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b req 0", done); end
`ifdef LATCH_FEED_STATS_EN
        checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset_xfer_cnt got %0d req 0", xfer_cnt); end
`endif
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b req 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b req 0", busy); end
        checks++; if (f_in_ready !== 1'b1) begin errors++; $display("FAIL release_fast_in_ready got %b req 1", f_in_ready); end
    endtask

    task automatic test_single();
        wait_ready();
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0; in_data = 'x;
        checks++; if (latch_din !== 8'hA5) begin errors++; $display("FAIL single_din_t1 got %h req a5", latch_din); end
        checks++; if (latch_en !== 1'b0) begin errors++; $display("FAIL single_setup_en got %b req 0", latch_en); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL single_busy_t1 got busy=%b rdy=%b req 1/0", busy, in_ready); end
        step();
        checks++; if (latch_en !== 1'b1) begin errors++; $display("FAIL single_open_t2 got %b req 1", latch_en); end
        step();
        checks++; if (latch_en !== 1'b1) begin errors++; $display("FAIL single_open_t3 got %b req 1", latch_en); end
        step();
        checks++; if (latch_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_hold_t4 got en=%b busy=%b done=%b req 0/1/0", latch_en, busy, done); end
        checks++; if (latch_din !== 8'hA5) begin errors++; $display("FAIL single_hold_din got %h req a5", latch_din); end
        step();
        checks++; if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_done_t5 got done=%b rdy=%b busy=%b req 1/1/0", done, in_ready, busy); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b req 0", done); end
    endtask

    task automatic test_noise();
        wait_ready();
        in_valid = 1'b1; in_data = 8'hA5;
        step();
        for (int c = 1; c <= 4; c++) begin
            in_valid = c[0];
            in_data  = 8'hFF;
            checks++; if (latch_din !== 8'hA5 || in_ready !== 1'b0) begin errors++; $display("FAIL noise_cycle%0d got din=%h rdy=%b req a5/0", c, latch_din, in_ready); end
            if (c == 4) in_valid = 1'b0;
            step();
        end
        checks++; if (done !== 1'b1 || latch_din !== 8'hA5) begin errors++; $display("FAIL noise_done got done=%b din=%h req 1/a5", done, latch_din); end
        step();
        checks++; if (latch_din !== 8'hA5) begin errors++; $display("FAIL noise_after got %h req a5", latch_din); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int cyc = 0, last = -1, idx = 0, dones = 0;
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        wait_ready();
        in_valid = 1'b1; in_data = words[0];
        while (dones < 3 && cyc < 60) begin
            if (done === 1'b1) dones++;
            if (in_ready === 1'b1) begin
                if (idx < 3) begin
                    if (last >= 0) begin
                        checks++;
                        if (cyc - last != 5) begin errors++; $display("FAIL b2b_spacing got %0d req 5", cyc - last); end
                    end
                    last = cyc;
                    in_valid = 1'b1;
                    in_data = words[idx];
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (latch_en === 1'b1 && idx > 0) begin
                checks++;
                if (latch_din !== words[idx-1]) begin errors++; $display("FAIL b2b_open_din got %h req %h", latch_din, words[idx-1]); end
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (dones != 3) begin errors++; $display("FAIL b2b_dones got %0d req 3", dones); end
        checks++; if (latch_din !== 8'h03) begin errors++; $display("FAIL b2b_last_din got %h req 03", latch_din); end
    endtask

    task automatic test_reset_mid_open();
        wait_ready();
        in_valid = 1'b1; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (latch_en !== 1'b1 || latch_din !== 8'h5A) begin errors++; $display("FAIL rst_mid_pre got en=%b din=%h req 1/5a", latch_en, latch_din); end
        rst_n = 1'b0;
        step();
        checks++; if (latch_en !== 1'b0 || latch_din !== 8'h00) begin errors++; $display("FAIL rst_mid_en_din got en=%b din=%h req 0/00", latch_en, latch_din); end
        checks++; if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got done=%b busy=%b rdy=%b req 0/0/0", done, busy, in_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_release got rdy=%b done=%b req 1/0", in_ready, done); end
        in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (latch_en !== 1'b1 || latch_din !== 8'h3C) begin errors++; $display("FAIL rst_mid_next_open got en=%b din=%h req 1/3c", latch_en, latch_din); end
        repeat (3) step();
        checks++; if (done !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_next_done got done=%b rdy=%b req 1/1", done, in_ready); end
`ifdef LATCH_FEED_STATS_EN
        checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_xfer_cnt got %0d req 1", xfer_cnt); end
`endif
    endtask

    task automatic test_fast();
        for (int k = 1; k <= 4; k++) begin
            logic [7:0] w;
            int n = 0;
            w = 8'(k * 17);
            while (f_in_ready !== 1'b1 && n < 20) begin step(); n++; end
            checks++; if (f_in_ready !== 1'b1) begin errors++; $display("FAIL fast_wait_ready got %b req 1", f_in_ready); end
            f_valid = 1'b1; f_data = w;
            step();
            f_valid = 1'b0;
            checks++; if (f_latch_en !== 1'b1 || f_latch_din !== w) begin errors++; $display("FAIL fast_open_t1 got en=%b din=%h req 1/%h", f_latch_en, f_latch_din, w); end
            step();
            checks++; if (f_latch_en !== 1'b1) begin errors++; $display("FAIL fast_open_t2 got %b req 1", f_latch_en); end
            step();
            checks++; if (f_done !== 1'b1 || f_in_ready !== 1'b1 || f_latch_en !== 1'b0) begin errors++; $display("FAIL fast_done got done=%b rdy=%b en=%b req 1/1/0", f_done, f_in_ready, f_latch_en); end
`ifdef LATCH_FEED_STATS_EN
            checks++; if (f_xfer_cnt !== 2'(k)) begin errors++; $display("FAIL fast_xfer_cnt got %0d req %0d", f_xfer_cnt, k % 4); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_noise();
        test_back_to_back();
        test_reset_mid_open();
        test_fast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
